ik_dls_step: RTL and testbench



---
 rtl/ik_dls_step.sv | 227 ++++++++++++++++++++++
 tb/tb_ik_dls_step.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ik_dls_step.sv
// ik_dls_step -- one damped-least-squares IK joint update.
//
//   error = target - pose, delta = DLS * error, q_out = q_in + delta
//
// A single shared signed multiplier-accumulator walks the NJ x 6 DLS matrix.
// The matrix is walked column-fastest. A start/done handshake brackets each
// iteration. Convergence is detected when every error component is within
// TOL. In that case the MAC pass is skipped. Rotational joints are wrapped
// back into [-PI_FX, +PI_FX] with a single correction.
//
// Optional build macro: IK_DLS_CLAMP_EN
//   When defined, each delta[j] is saturated to [-MAX_STEP, +MAX_STEP].
//   When undefined, delta is applied unclamped and MAX_STEP is unused.
//
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        clock enable; all state frozen when low
//   start      in   1        request one iteration (sampled only in IDLE)
//   dls        in   NJ*6*W   DLS matrix; row j = joint j, col k = error comp k
//   target     in   6*W      desired x,y,z,i,j,k
//   pose       in   6*W      current x,y,z,i,j,k
//   joint_type in   NJ       1 = rotational, 0 = translational
//   q_in       in   NJ*W     current joint variables
//   q_out      out  NJ*W     updated joint variables
//   busy       out  1        high outside IDLE
//   done       out  1        one-cycle (enabled) pulse at end of iteration
//   converged  out  1        valid with done; sticky until next accepted start

module ik_dls_step #(
    parameter int             NJ       = 6,
    parameter int             W        = 36,
    parameter int             FRAC     = 16,
    parameter logic [W-1:0]   TOL      = 36'h0_0000_0041,
    parameter logic [W-1:0]   MAX_STEP = 36'h0_0000_4000,
    parameter logic [W-1:0]   PI_FX    = 36'h0_0003_243F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic [NJ*6*W-1:0]   dls,
    input  logic [6*W-1:0]      target,
    input  logic [6*W-1:0]      pose,
    input  logic [NJ-1:0]       joint_type,
    input  logic [NJ*W-1:0]     q_in,
    output logic [NJ*W-1:0]     q_out,
    output logic                busy,
    output logic                done,
    output logic                converged
);

    localparam int ACC_W = 2*W + 3;
    localparam int JW    = (NJ > 1) ? $clog2(NJ) : 1;

    localparam logic signed [W-1:0] PI_POS = PI_FX;
    localparam logic signed [W-1:0] PI_NEG = -PI_FX;
    localparam logic signed [W-1:0] PI_TWO = PI_FX << 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MAC,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                     state;
    logic [NJ*6*W-1:0]          dls_r;
    logic [6*W-1:0]             target_r;
    logic [6*W-1:0]             pose_r;
    logic signed [W-1:0]        err_r   [6];
    logic signed [W-1:0]        delta_r [NJ];
    logic signed [ACC_W-1:0]    acc;
    logic [JW-1:0]              j_cnt;
    logic [2:0]                 k_cnt;

    // ------------------------------------------------------------------
    // Error vector and tolerance test (used in ERR)
    // ------------------------------------------------------------------
    logic signed [W-1:0]        err_c [6];
    logic                       within_tol;

    always_comb begin
        logic [W-1:0] mag;
        within_tol = 1'b1;
        mag        = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            err_c[k] = target_r[k*W +: W] - pose_r[k*W +: W];
            // Two's-complement negate; the most negative value maps to
            // 2^(W-1), which is always beyond any W-bit positive TOL.
            mag = err_c[k][W-1] ? (~err_c[k] + 1'b1) : err_c[k];
            if (mag > TOL)
                within_tol = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shared MAC datapath (used in MAC)
    // ------------------------------------------------------------------
    logic signed [W-1:0]        dls_sel;
    logic signed [W-1:0]        err_sel;
    logic signed [2*W-1:0]      prod;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    acc_shr;
    logic signed [W-1:0]        delta_c;

    always_comb begin
        dls_sel  = dls_r[(int'(j_cnt)*6 + int'(k_cnt))*W +: W];
        err_sel  = (k_cnt < 3'd6) ? err_r[k_cnt] : '0;
        prod     = dls_sel * err_sel;
        acc_next = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        acc_shr  = acc_next >>> FRAC;
`ifdef IK_DLS_CLAMP_EN
        // Saturate on the full-width shifted sum so oversized results
        // clamp instead of wrapping during truncation.
        if (acc_shr > $signed({{(ACC_W-W){1'b0}}, MAX_STEP}))
            delta_c = MAX_STEP;
        else if (acc_shr < -$signed({{(ACC_W-W){1'b0}}, MAX_STEP}))
            delta_c = -MAX_STEP;
        else
            delta_c = acc_shr[W-1:0];
`else
        delta_c = acc_shr[W-1:0];
`endif
    end

    // ------------------------------------------------------------------
    // Joint update with rotational wrap (used in APPLY)
    // ------------------------------------------------------------------
    logic [NJ*W-1:0]            q_new;

    always_comb begin
        logic signed [W-1:0] s;
        q_new = '0;
        s     = '0;
        for (int unsigned j = 0; j < NJ; j++) begin
            s = $signed(q_out[j*W +: W]) + delta_r[j];
            if (joint_type[j]) begin
                if (s > PI_POS)
                    s = s - PI_TWO;
                else if (s < PI_NEG)
                    s = s + PI_TWO;
            end
            q_new[j*W +: W] = s;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            q_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            dls_r     <= '0;
            target_r  <= '0;
            pose_r    <= '0;
            acc       <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            for (int unsigned k = 0; k < 6; k++)
                err_r[k] <= '0;
            for (int unsigned j = 0; j < NJ; j++)
                delta_r[j] <= '0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_out     <= q_in;
                        dls_r     <= dls;
                        target_r  <= target;
                        pose_r    <= pose;
                        converged <= 1'b0;
                        busy      <= 1'b1;
                        acc       <= '0;
                        j_cnt     <= '0;
                        k_cnt     <= '0;
                        state     <= S_ERR;
                    end
                end
                S_ERR: begin
                    for (int unsigned k = 0; k < 6; k++)
                        err_r[k] <= err_c[k];
                    if (within_tol) begin
                        converged <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (k_cnt == 3'd5) begin
                        delta_r[j_cnt] <= delta_c;
                        acc            <= '0;
                        k_cnt          <= '0;
                        if (j_cnt == JW'(NJ-1)) begin
                            j_cnt <= '0;
                            state <= S_APPLY;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                S_APPLY: begin
                    q_out <= q_new;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ik_dls_step.sv
// tb_ik_dls_step -- self-checking bench for ik_dls_step (NJ=6, W=36).
// Table-driven single iterations plus hand-written control sequences
// (clock-enable stall, held done, start while busy, mid-run reset).
// Latency convention: the start-accepting edge is edge 0; done first seen
// after edge n is reported as cycle n+1.

module tb_ik_dls_step;

    localparam int NJ = 6;
    localparam int W  = 36;

`ifdef IK_DLS_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                start;
    logic [NJ*6*W-1:0]   dls;
    logic [6*W-1:0]      target;
    logic [6*W-1:0]      pose;
    logic [NJ-1:0]       joint_type;
    logic [NJ*W-1:0]     q_in;
    logic [NJ*W-1:0]     q_out;
    logic                busy;
    logic                done;
    logic                converged;

    ik_dls_step #(.NJ(NJ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .dls        (dls),
        .target     (target),
        .pose       (pose),
        .joint_type (joint_type),
        .q_in       (q_in),
        .q_out      (q_out),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] px;
        logic [W-1:0] ty;
        logic         jt0;
        logic [W-1:0] q0;
        logic         exp_conv;
        logic [W-1:0] exp_q0;
        logic [W-1:0] exp_q1;
        int           exp_lat;
    } vec_t;

    vec_t vecs[15];

    // Load stimulus for one vector; q1 = 0x500, q[j] = 0x100*j for j >= 2.
    task automatic load(input vec_t v);
        target            = '0;
        pose              = '0;
        target[0 +: W]    = v.tx;
        target[W +: W]    = v.ty;
        pose[0 +: W]      = v.px;
        joint_type        = '0;
        joint_type[0]     = v.jt0;
        q_in              = '0;
        q_in[0 +: W]      = v.q0;
        q_in[W +: W]      = 36'h500;
        for (int j = 2; j < NJ; j++)
            q_in[j*W +: W] = W'(j * 256);
    endtask

    // Start one iteration and wait (bounded) for done. lat = -1 on timeout.
    task automatic run_iter(output int lat);
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic check_rest(input string nm);
        for (int j = 2; j < NJ; j++)
            check(nm, 64'(q_out[j*W +: W]), 64'(j * 256));
    endtask

    initial begin
        int lat;
        int n_done;

        // Table: err only in x (and y), identity DLS with dls[0][1] = 0.5.
        vecs[0]  = '{36'h0,      36'h0,    36'h0,     1'b0, 36'h1234,  1'b1, 36'h1234, 36'h500, 2};
        vecs[1]  = '{36'h41,     36'h0,    36'h0,     1'b0, 36'h1000,  1'b1, 36'h1000, 36'h500, 2};
        vecs[2]  = '{-36'h41,    36'h0,    36'h0,     1'b0, 36'h1000,  1'b1, 36'h1000, 36'h500, 2};
        vecs[3]  = '{36'h42,     36'h0,    36'h0,     1'b0, 36'h1000,  1'b0, 36'h1042, 36'h500, 39};
        vecs[4]  = '{36'h2000,   36'h0,    36'h0,     1'b0, 36'h1000,  1'b0, 36'h3000, 36'h500, 39};
        vecs[5]  = '{36'h5000,   36'h3000, 36'h0,     1'b0, 36'h1000,  1'b0, 36'h3000, 36'h500, 39};
        vecs[6]  = '{36'h20000,  36'h0,    36'h0,     1'b0, 36'h1000,  1'b0,
                     CLAMP ? 36'h5000 : 36'h21000, 36'h500, 39};
        vecs[7]  = '{-36'h20000, 36'h0,    36'h0,     1'b0, 36'h1000,  1'b0,
                     CLAMP ? -36'h3000 : -36'h1F000, 36'h500, 39};
        vecs[8]  = '{36'h4000,   36'h0,    36'h0,     1'b1, 36'h30000, 1'b0, -36'h3087E, 36'h500, 39};
        vecs[9]  = '{-36'h4000,  36'h0,    36'h0,     1'b1, -36'h30000,1'b0, 36'h3087E, 36'h500, 39};
        vecs[10] = '{36'h2000,   36'h0,    36'h0,     1'b1, 36'h1000,  1'b0, 36'h3000, 36'h500, 39};
        vecs[11] = '{36'h2000,   36'h0,    36'h2000,  1'b0, 36'h1000,  1'b0, 36'h4000, 36'h2500, 39};
        vecs[12] = '{36'h2000,   36'h0,    -36'h3,    1'b0, 36'h1000,  1'b0, 36'h2FFE, 36'h4FD, 39};
        vecs[13] = '{36'h0,      36'h0,    36'h42,    1'b0, 36'h1000,  1'b0, 36'h1021, 36'h542, 39};
        vecs[14] = '{36'h20000,  36'h0,    36'h0,     1'b1, 36'h30000, 1'b0,
                     CLAMP ? -36'h3087E : 36'h50000 - 36'h6487E, 36'h500, 39};

        dls = '0;
        for (int j = 0; j < NJ; j++)
            dls[(j*6 + j)*W +: W] = 36'h10000;
        dls[(0*6 + 1)*W +: W] = 36'h8000;

        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        load(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_done",  64'(done), 64'd0);
        check("reset_conv",  64'(converged), 64'd0);
        check("reset_q_out", 64'(q_out[0 +: W]) | 64'(q_out[W +: W]), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            load(vecs[i]);
            run_iter(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_converged", i), 64'(converged), 64'(vecs[i].exp_conv));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            check($sformatf("v%0d_q0", i), 64'(q_out[0 +: W]), 64'(vecs[i].exp_q0));
            check($sformatf("v%0d_q1", i), 64'(q_out[W +: W]), 64'(vecs[i].exp_q1));
            check_rest($sformatf("v%0d_q_rest", i));
        end

        // Done pulse is held while en is low, then clears.
        load(vecs[0]);
        run_iter(lat);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(done), 64'd1);
        check("hold_busy", 64'(busy), 64'd1);
        en = 1'b1;
        @(posedge clk); #1;
        check("release_done", 64'(done), 64'd0);
        check("release_busy", 64'(busy), 64'd0);

        // Five-cycle enable stall during MAC.
        load(vecs[4]);
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 10) en = 1'b0;
            if (n == 15) en = 1'b1;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        check("stall_latency", 64'(lat), 64'd44);
        check("stall_q0", 64'(q_out[0 +: W]), 64'h3000);

        // start pulsed while busy is ignored (new q_in must not be taken).
        load(vecs[4]);
        lat = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 5) begin
                start        = 1'b1;
                q_in[0 +: W] = 36'h7777;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        check("busy_start_latency", 64'(lat), 64'd39);
        check("busy_start_q0", 64'(q_out[0 +: W]), 64'h3000);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_idle", 64'(busy), 64'd0);

        // Reset mid-iteration: immediate abort, no done pulse afterwards.
        load(vecs[4]);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q_out_zero", 64'(q_out == '0), 64'd1);
        #2;
        rst_n  = 1'b1;
        n_done = 0;
        for (int n = 0; n < 45; n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
